alu_arbiter: RTL and testbench
==============================

// Module: alu_arbiter
// PURPOSE
//  Shares one combinational ALU datapath (add/sub/mul, bitwise, shift, compare)
//  between NREQ requesters using round-robin arbitration. Grants one valid/ready
//  request per cycle and registers the result into a single response channel.
//  The response is tagged with the requester index. Sits between compute
//  engines and the shared arithmetic resource.
// PARAMETERS
//  WIDTH  32  operand and result width in bits
//  NREQ    4  number of requesters (>=2); IDW = $clog2(NREQ) is a derived localparam
// PORTS
//  clk         in   1           clock, rising edge
//  reset       in   1           asynchronous, active-low reset
//  req_valid   in   NREQ        per-requester request valid
//  req_ready   out  NREQ        per-requester accept; at most one bit high
//  req_op      in   NREQ*4      opcode, requester i in bits [4i+3:4i]
//  req_left    in   NREQ*WIDTH  left operand, requester i in slice i
//  req_right   in   NREQ*WIDTH  right operand or shift amount, slice i
//  resp_valid  out  1           response register holds a result
//  resp_ready  in   1           consumer accepts the response
//  resp_data   out  WIDTH       result
//  resp_id     out  IDW         index of the requester that produced the result
//  resp_err    out  1           opcode was illegal
// BEHAVIOUR
//  Reset (reset==0, async): resp_valid=0, resp_data=0, resp_id=0, resp_err=0.
//   The RR pointer is set to 0, so requester 0 has top priority. A result in
//   flight is discarded.
//  accept = ~resp_valid | resp_ready  (output slot free, or freed this cycle).
//  Arbitration: search req_valid starting at index ptr, wrapping modulo NREQ.
//   The first set bit is the winner g.
//   req_ready[g] = accept && winner exists. All other req_ready bits are 0.
//   req_ready depends combinationally on req_valid. Requesters must not derive
//   req_valid from req_ready.
//  Transfer on an edge where req_valid[g] && req_ready[g]:
//   resp_data <= ALU(op,left,right) of g; resp_id <= g; resp_err <= illegal;
//   resp_valid <= 1; ptr <= (g+1) mod NREQ.
//  An edge with resp_valid && resp_ready and no transfer: resp_valid <= 0.
//   Data, id and err hold their values.
//  No transfer and resp_ready=0: all registers hold. ptr changes only on a transfer.
//  Latency: 1 cycle from accept edge to resp_valid. Throughput: 1 result per
//   cycle when resp_ready stays high. A simultaneous drain and grant is a
//   back-to-back transfer with no bubble.
//  Opcodes (all unsigned unless stated; results truncated to WIDTH):
//   0 ADD  1 SUB (wraps)  2 MUL (low WIDTH bits)  3 AND  4 OR  5 XOR
//   6 SHL  7 SHR (logical)  8 SRA (left treated as signed)
//   9 LT  10 EQ  11 GT (1-bit result, zero-extended to WIDTH)
//   12-15 illegal: resp_data=0, resp_err=1. These are still granted and responded.
//  Shifts use the full right operand. An amount >= WIDTH gives 0 for SHL/SHR
//   and all sign bits for SRA.
//  Stall: while resp_valid=1 and resp_ready=0, every req_ready is 0.
//   Requests must hold stable and the pointer does not move.
//  No valid requests: req_ready=0 and ptr holds.
// TESTING
//  1 Reset: assert reset low mid-stream -> resp_valid=0, req_ready=0, next grant goes to req 0.
//  2 Single op, WIDTH=32: req1 ADD 0xFFFFFFFF+2 -> next cycle resp_data=1, id=1, err=0.
//  3 Fairness: all 4 requesters valid, resp_ready=1 -> grants 0,1,2,3,0,... one per cycle, no gaps.
//  4 Backpressure: resp_ready=0 for 3 cycles with 2 requesters pending -> req_ready=0,
//    resp held stable, pointer unchanged; grants resume in RR order when released.
//  5 ALU edges: SRA 0x80000000 by 40 -> 0xFFFFFFFF; SHL 1 by 32 -> 0;
//    LT 3,5 -> 1; MUL 0x10000*0x10000 -> 0.
//  6 Illegal op 13 from req2 -> resp_data=0, err=1, id=2; pointer advances to 3.

Source files
------------

// File: rtl/alu_arbiter_if.sv
// Request/response bundle between compute engines and the shared ALU arbiter.
interface alu_arbiter_if #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned NREQ  = 4,
  parameter int unsigned IDW   = $clog2(NREQ)
);
  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ*4-1:0]     req_op;
  logic [NREQ*WIDTH-1:0] req_left;
  logic [NREQ*WIDTH-1:0] req_right;
  logic                  resp_valid;
  logic                  resp_ready;
  logic [WIDTH-1:0]      resp_data;
  logic [IDW-1:0]        resp_id;
  logic                  resp_err;

  // requesters plus the response consumer
  modport master (
    output req_valid, req_op, req_left, req_right, resp_ready,
    input  req_ready, resp_valid, resp_data, resp_id, resp_err
  );

  // the arbiter
  modport slave (
    input  req_valid, req_op, req_left, req_right, resp_ready,
    output req_ready, resp_valid, resp_data, resp_id, resp_err
  );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one combinational ALU among NREQ requesters,
// with a single registered, id-tagged response slot.
module alu_arbiter #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned NREQ  = 4
) (
  input logic          clk,
  input logic          reset,
  alu_arbiter_if.slave bus
);
  localparam int unsigned IDW = $clog2(NREQ);
  localparam int unsigned OPW = 4;

  localparam logic [OPW-1:0] OP_ADD = 4'd0;
  localparam logic [OPW-1:0] OP_SUB = 4'd1;
  localparam logic [OPW-1:0] OP_MUL = 4'd2;
  localparam logic [OPW-1:0] OP_AND = 4'd3;
  localparam logic [OPW-1:0] OP_OR  = 4'd4;
  localparam logic [OPW-1:0] OP_XOR = 4'd5;
  localparam logic [OPW-1:0] OP_SHL = 4'd6;
  localparam logic [OPW-1:0] OP_SHR = 4'd7;
  localparam logic [OPW-1:0] OP_SRA = 4'd8;
  localparam logic [OPW-1:0] OP_LT  = 4'd9;
  localparam logic [OPW-1:0] OP_EQ  = 4'd10;
  localparam logic [OPW-1:0] OP_GT  = 4'd11;

  logic [IDW-1:0]   ptr;
  logic [IDW-1:0]   win;
  logic [IDW-1:0]   cand;
  logic             found;
  logic             accept;
  logic             xfer;
  logic [OPW-1:0]   op_a    [NREQ];
  logic [WIDTH-1:0] left_a  [NREQ];
  logic [WIDTH-1:0] right_a [NREQ];
  logic [OPW-1:0]   sel_op;
  logic [WIDTH-1:0] sel_l;
  logic [WIDTH-1:0] sel_r;
  logic             big_shift;
  logic [WIDTH-1:0] alu_res;
  logic             alu_err;

  // unpack flat request buses into per-requester arrays
  always_comb begin
    for (int unsigned i = 0; i < NREQ; i++) begin
      op_a[i]    = bus.req_op[i*OPW +: OPW];
      left_a[i]  = bus.req_left[i*WIDTH +: WIDTH];
      right_a[i] = bus.req_right[i*WIDTH +: WIDTH];
    end
  end

  // first valid requester at or after ptr, wrapping
  always_comb begin
    found = 1'b0;
    win   = ptr;
    cand  = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      cand = IDW'((32'(ptr) + k) % NREQ);
      if (!found && bus.req_valid[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
  end

  // reset also gates grants so nothing is accepted while held in reset
  assign accept = ~bus.resp_valid | bus.resp_ready;
  assign xfer   = found & accept & reset;

  always_comb begin
    bus.req_ready      = '0;
    bus.req_ready[win] = xfer;
  end

  assign sel_op    = op_a[win];
  assign sel_l     = left_a[win];
  assign sel_r     = right_a[win];
  assign big_shift = (sel_r >= WIDTH'(WIDTH));

  // shared datapath
  always_comb begin
    alu_res = '0;
    alu_err = 1'b0;
    case (sel_op)
      OP_ADD: alu_res = sel_l + sel_r;
      OP_SUB: alu_res = sel_l - sel_r;
      OP_MUL: alu_res = sel_l * sel_r;
      OP_AND: alu_res = sel_l & sel_r;
      OP_OR:  alu_res = sel_l | sel_r;
      OP_XOR: alu_res = sel_l ^ sel_r;
      OP_SHL: alu_res = big_shift ? '0 : (sel_l << sel_r);
      OP_SHR: alu_res = big_shift ? '0 : (sel_l >> sel_r);
      OP_SRA: alu_res = big_shift ? {WIDTH{sel_l[WIDTH-1]}}
                                  : WIDTH'($signed(sel_l) >>> sel_r);
      OP_LT:  alu_res = {{(WIDTH-1){1'b0}}, (sel_l < sel_r)};
      OP_EQ:  alu_res = {{(WIDTH-1){1'b0}}, (sel_l == sel_r)};
      OP_GT:  alu_res = {{(WIDTH-1){1'b0}}, (sel_l > sel_r)};
      default: begin
        alu_res = '0;
        alu_err = 1'b1;
      end
    endcase
  end

  // response slot and round-robin pointer
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr            <= '0;
      bus.resp_valid <= 1'b0;
      bus.resp_data  <= '0;
      bus.resp_id    <= '0;
      bus.resp_err   <= 1'b0;
    end else if (xfer) begin
      ptr            <= (win == IDW'(NREQ - 1)) ? '0 : win + IDW'(1);
      bus.resp_valid <= 1'b1;
      bus.resp_data  <= alu_res;
      bus.resp_id    <= win;
      bus.resp_err   <= alu_err;
    end else if (bus.resp_ready) begin
      bus.resp_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter: directed requests push expected responses,
// a negedge monitor pops and compares every accepted response.
module tb_alu_arbiter;
  localparam int unsigned WIDTH = 32;
  localparam int unsigned NREQ  = 4;

  typedef struct {
    logic [31:0] d;
    logic [1:0]  id;
    logic        e;
  } exp_t;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;
  exp_t sb[$];

  alu_arbiter_if #(.WIDTH(WIDTH), .NREQ(NREQ)) bus ();

  alu_arbiter #(.WIDTH(WIDTH), .NREQ(NREQ)) dut (
    .clk  (clk),
    .reset(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
    end
  endtask

  task automatic push(input logic [31:0] d, input logic [1:0] id, input logic e);
    exp_t x;
    x.d  = d;
    x.id = id;
    x.e  = e;
    sb.push_back(x);
  endtask

  task automatic load(input int i, input logic [3:0] op, input logic [31:0] l, input logic [31:0] r);
    bus.req_op[i*4 +: 4]         = op;
    bus.req_left[i*32 +: 32]     = l;
    bus.req_right[i*32 +: 32]    = r;
    bus.req_valid[i]             = 1'b1;
  endtask

  // one cycle: check which requester is granted, then drop granted valids
  task automatic expect_grant(input int g, input string name);
    logic [3:0] snap;
    logic [3:0] exp;
    @(negedge clk);
    snap = bus.req_ready & bus.req_valid;
    exp  = (g < 0) ? 4'b0000 : 4'(1 << g);
    chk(name, 32'(bus.req_ready), 32'(exp));
    @(posedge clk);
    #1;
    bus.req_valid = bus.req_valid & ~snap;
  endtask

  // response monitor
  always @(negedge clk) begin
    exp_t e;
    checks++;
    if ($countones(bus.req_ready) > 1) begin
      failures++;
      $display("FAIL ready_onehot actual=0b%04b required=at most one bit", bus.req_ready);
    end
    if (bus.resp_valid === 1'b1 && bus.resp_ready === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_resp actual data=0x%08h id=%0d required=no response",
                 bus.resp_data, bus.resp_id);
      end else begin
        e = sb.pop_front();
        chk("resp_data", bus.resp_data, e.d);
        chk("resp_id", 32'(bus.resp_id), 32'(e.id));
        chk("resp_err", 32'(bus.resp_err), 32'(e.e));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    checks         = 0;
    failures       = 0;
    rst_n          = 1'b0;
    bus.req_valid  = '0;
    bus.req_op     = '0;
    bus.req_left   = '0;
    bus.req_right  = '0;
    bus.resp_ready = 1'b1;

    // reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
    chk("rst_resp_data", bus.resp_data, 32'd0);
    chk("rst_resp_id", 32'(bus.resp_id), 32'd0);
    chk("rst_resp_err", 32'(bus.resp_err), 32'd0);
    chk("rst_req_ready", 32'(bus.req_ready), 32'd0);
    rst_n = 1'b1;

    // fairness: all four valid, then req0 re-requests
    load(0, 4'd0, 32'd10, 32'd20);
    load(1, 4'd1, 32'd5, 32'd7);
    load(2, 4'd2, 32'd3, 32'd7);
    load(3, 4'd5, 32'h0000F0F0, 32'h0000FF00);
    push(32'd30, 2'd0, 1'b0);
    push(32'hFFFFFFFE, 2'd1, 1'b0);
    push(32'd21, 2'd2, 1'b0);
    push(32'h00000FF0, 2'd3, 1'b0);
    expect_grant(0, "rr_g0");
    load(0, 4'd3, 32'hFF00FF00, 32'h0FF00FF0);
    push(32'h0F000F00, 2'd0, 1'b0);
    expect_grant(1, "rr_g1");
    expect_grant(2, "rr_g2");
    expect_grant(3, "rr_g3");
    expect_grant(0, "rr_g0_wrap");
    expect_grant(-1, "rr_idle");

    // single op with 1-cycle latency
    load(1, 4'd0, 32'hFFFFFFFF, 32'd2);
    push(32'd1, 2'd1, 1'b0);
    expect_grant(1, "single_g1");
    chk("single_valid", 32'(bus.resp_valid), 32'd1);
    chk("single_data", bus.resp_data, 32'd1);
    expect_grant(-1, "single_idle");

    // backpressure: pointer at 2, req3 and req0 wait behind a stalled response
    load(2, 4'd7, 32'h00000080, 32'd4);
    load(3, 4'd4, 32'h0000000F, 32'h000000F0);
    load(0, 4'd11, 32'd9, 32'd4);
    push(32'd8, 2'd2, 1'b0);
    expect_grant(2, "bp_g2");
    bus.resp_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      expect_grant(-1, "bp_stall");
      chk("bp_hold_valid", 32'(bus.resp_valid), 32'd1);
      chk("bp_hold_data", bus.resp_data, 32'd8);
      chk("bp_hold_id", 32'(bus.resp_id), 32'd2);
    end
    bus.resp_ready = 1'b1;
    push(32'h000000FF, 2'd3, 1'b0);
    push(32'd1, 2'd0, 1'b0);
    expect_grant(3, "bp_g3");
    expect_grant(0, "bp_g0");
    expect_grant(-1, "bp_idle");

    // ALU edge cases, pointer at 1
    load(1, 4'd8, 32'h80000000, 32'd40);
    load(2, 4'd6, 32'd1, 32'd32);
    load(3, 4'd9, 32'd3, 32'd5);
    load(0, 4'd2, 32'h00010000, 32'h00010000);
    push(32'hFFFFFFFF, 2'd1, 1'b0);
    push(32'd0, 2'd2, 1'b0);
    push(32'd1, 2'd3, 1'b0);
    push(32'd0, 2'd0, 1'b0);
    expect_grant(1, "alu_g1");
    expect_grant(2, "alu_g2");
    expect_grant(3, "alu_g3");
    expect_grant(0, "alu_g0");
    expect_grant(-1, "alu_idle");

    // illegal opcode from req2; pointer must then sit at 3
    load(2, 4'd13, 32'h12345678, 32'h9ABCDEF0);
    push(32'd0, 2'd2, 1'b1);
    expect_grant(2, "ill_g2");
    load(0, 4'd10, 32'd7, 32'd7);
    load(3, 4'd1, 32'd100, 32'd1);
    push(32'd99, 2'd3, 1'b0);
    push(32'd1, 2'd0, 1'b0);
    expect_grant(3, "ill_next_g3");
    expect_grant(0, "ill_next_g0");
    expect_grant(-1, "ill_idle");

    // reset mid-stream discards the in-flight result and restarts at req0
    bus.resp_ready = 1'b0;
    load(1, 4'd0, 32'd1, 32'd1);
    load(3, 4'd0, 32'd3, 32'd3);
    expect_grant(1, "mid_g1");
    rst_n = 1'b0;
    #2;
    chk("mid_rst_valid", 32'(bus.resp_valid), 32'd0);
    chk("mid_rst_ready", 32'(bus.req_ready), 32'd0);
    @(posedge clk);
    #1;
    rst_n          = 1'b1;
    bus.resp_ready = 1'b1;
    load(0, 4'd0, 32'd5, 32'd5);
    push(32'd10, 2'd0, 1'b0);
    push(32'd6, 2'd3, 1'b0);
    expect_grant(0, "post_rst_g0");
    expect_grant(3, "post_rst_g3");
    repeat (3) expect_grant(-1, "drain_idle");

    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
